// File: rtl/mux421_monitor_if.sv
// Bus between the 4:1 mux stimulus/DUV side and the monitor.
// Carries the monitor's stimulus inputs and its statistics outputs.
interface mux421_monitor_if #(parameter int CNT_W = 16);
    logic             Clear;
    logic             Valid;
    logic             In0, In1, In2, In3;
    logic             Sel0, Sel1;
    logic             Out;
    logic             Mismatch;
    logic [CNT_W-1:0] VectorCount;
    logic [CNT_W-1:0] ErrorCount;
    logic [63:0]      Coverage;
    logic             CoverageFull;
    logic [1:0]       Status;
    logic             Pass;

    modport master (
        output Clear, Valid, In0, In1, In2, In3, Sel0, Sel1, Out,
        input  Mismatch, VectorCount, ErrorCount, Coverage, CoverageFull, Status, Pass
    );

    modport slave (
        input  Clear, Valid, In0, In1, In2, In3, Sel0, Sel1, Out,
        output Mismatch, VectorCount, ErrorCount, Coverage, CoverageFull, Status, Pass
    );
endinterface

// File: rtl/mux421_monitor.sv
// Clocked self-checking monitor for a 4:1 mux DUV with configurable DUV latency.
// Define MUX421_MONITOR_LOG_EN to print mismatches and the final verdict in simulation.
module mux421_monitor #(
    parameter int LATENCY = 0,
    parameter int CNT_W   = 16
) (
    input  logic               Clock,
    input  logic               nReset,
    mux421_monitor_if.slave    bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PASS = 2'b10, FAIL = 2'b11} state_t;
    localparam int STAGES = LATENCY;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] vec_cnt, vec_nxt;
    logic [CNT_W-1:0] err_cnt, err_nxt;
    logic [63:0]      cov, cov_nxt;
    logic             mismatch;

    logic [3:0] din;
    logic [1:0] sel;
    logic       exp0;
    logic [5:0] idx0;
    logic       tail_vld, tail_exp, pend_nxt;
    logic [5:0] tail_idx;
    logic       cmp_fire, cmp_fail;

    assign din  = {bus.In3, bus.In2, bus.In1, bus.In0};
    assign sel  = {bus.Sel1, bus.Sel0};
    assign exp0 = din[sel];
    assign idx0 = {sel, din};

    generate
        if (STAGES > 0) begin : g_pipe
            logic [STAGES:1]      vld_q, exp_q;
            logic [STAGES:1][5:0] idx_q;
            logic [STAGES:0]      vld_pipe, exp_pipe;
            logic [STAGES:0][5:0] idx_pipe;

            assign vld_pipe = {vld_q, bus.Valid};
            assign exp_pipe = {exp_q, exp0};
            assign idx_pipe = {idx_q, idx0};

            always_ff @(posedge Clock or negedge nReset) begin
                if (!nReset) begin
                    vld_q <= '0;
                    exp_q <= '0;
                    idx_q <= '0;
                end else if (bus.Clear) begin
                    vld_q <= '0;
                    exp_q <= '0;
                    idx_q <= '0;
                end else begin
                    vld_q <= vld_pipe[STAGES-1:0];
                    exp_q <= exp_pipe[STAGES-1:0];
                    idx_q <= idx_pipe[STAGES-1:0];
                end
            end

            assign tail_vld = vld_pipe[STAGES];
            assign tail_exp = exp_pipe[STAGES];
            assign tail_idx = idx_pipe[STAGES];
            // Entries still owed a comparison once this edge has shifted the line
            assign pend_nxt = |vld_pipe[STAGES-1:0];
        end else begin : g_nopipe
            assign tail_vld = bus.Valid;
            assign tail_exp = exp0;
            assign tail_idx = idx0;
            assign pend_nxt = 1'b0;
        end
    endgenerate

    // Case-inequality so an X/Z from the DUV is reported as a failure
    assign cmp_fire = tail_vld & ~bus.Clear;
    assign cmp_fail = cmp_fire & (bus.Out !== tail_exp);

    always_comb begin
        vec_nxt = vec_cnt;
        err_nxt = err_cnt;
        cov_nxt = cov;
        if (cmp_fire) begin
            if (vec_cnt != '1) vec_nxt = vec_cnt + 1'b1;
            cov_nxt[tail_idx] = 1'b1;
        end
        if (cmp_fail && err_cnt != '1) err_nxt = err_cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        if (bus.Clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (cmp_fire) state_nxt = cmp_fail ? FAIL : RUN;
                RUN: begin
                    if (cmp_fail) state_nxt = FAIL;
                    else if (&cov_nxt && err_nxt == '0 && !pend_nxt) state_nxt = PASS;
                end
                PASS:    if (cmp_fail) state_nxt = FAIL;
                FAIL:    state_nxt = FAIL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            vec_cnt  <= '0;
            err_cnt  <= '0;
            cov      <= '0;
            mismatch <= 1'b0;
        end else if (bus.Clear) begin
            state    <= IDLE;
            vec_cnt  <= '0;
            err_cnt  <= '0;
            cov      <= '0;
            mismatch <= 1'b0;
        end else begin
            state    <= state_nxt;
            vec_cnt  <= vec_nxt;
            err_cnt  <= err_nxt;
            cov      <= cov_nxt;
            mismatch <= cmp_fail;
        end
    end

    assign bus.Mismatch     = mismatch;
    assign bus.VectorCount  = vec_cnt;
    assign bus.ErrorCount   = err_cnt;
    assign bus.Coverage     = cov;
    assign bus.CoverageFull = &cov;
    assign bus.Status       = state;
    assign bus.Pass         = (state == PASS);

`ifdef MUX421_MONITOR_LOG_EN
    always @(posedge Clock) begin
        if (nReset && cmp_fail)
            $display("%0t mux421_monitor: mismatch Sel1=%b Sel0=%b In3..0=%b expected=%b Out=%b",
                     $time, tail_idx[5], tail_idx[4], tail_idx[3:0], tail_exp, bus.Out);
        if (nReset && !bus.Clear && state_nxt != state && (state_nxt == PASS || state_nxt == FAIL))
            $display("%0t mux421_monitor: %s vectors=%0d errors=%0d",
                     $time, (state_nxt == PASS) ? "PASS" : "FAIL", vec_nxt, err_nxt);
    end
`endif
endmodule

// File: tb/tb_mux421_monitor.sv
// Self-checking bench for mux421_monitor: five instances share one stimulus stream,
// differing in LATENCY, CNT_W and how their DUV output is modelled.
module tb_mux421_monitor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear, valid;
    logic [3:0] din;
    logic [1:0] sel;
    logic       inj0, xmode0, inv3, invs;
    logic       gold;
    bit         gd1, gd2, gd3;

    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    int  sb_dut = 0;
    int  sb_lat = 0;
    logic sb_q[$];

    always #5 clk = ~clk;

    assign gold = din[sel];
    always @(posedge clk) begin
        gd1 <= gold;
        gd2 <= gd1;
        gd3 <= gd2;
    end

    mux421_monitor_if #(.CNT_W(16)) bus0  ();
    mux421_monitor_if #(.CNT_W(16)) bus2  ();
    mux421_monitor_if #(.CNT_W(16)) bus2u ();
    mux421_monitor_if #(.CNT_W(16)) bus3  ();
    mux421_monitor_if #(.CNT_W(4))  buss  ();

    assign {bus0.Clear,  bus0.Valid,  bus0.Sel1,  bus0.Sel0,  bus0.In3,  bus0.In2,  bus0.In1,  bus0.In0}  = {clear, valid, sel, din};
    assign {bus2.Clear,  bus2.Valid,  bus2.Sel1,  bus2.Sel0,  bus2.In3,  bus2.In2,  bus2.In1,  bus2.In0}  = {clear, valid, sel, din};
    assign {bus2u.Clear, bus2u.Valid, bus2u.Sel1, bus2u.Sel0, bus2u.In3, bus2u.In2, bus2u.In1, bus2u.In0} = {clear, valid, sel, din};
    assign {bus3.Clear,  bus3.Valid,  bus3.Sel1,  bus3.Sel0,  bus3.In3,  bus3.In2,  bus3.In1,  bus3.In0}  = {clear, valid, sel, din};
    assign {buss.Clear,  buss.Valid,  buss.Sel1,  buss.Sel0,  buss.In3,  buss.In2,  buss.In1,  buss.In0}  = {clear, valid, sel, din};

    assign bus0.Out  = xmode0 ? 1'bx : (gold ^ inj0);
    assign bus2.Out  = gd2;
    assign bus2u.Out = gold;
    assign bus3.Out  = gd3 ^ inv3;
    assign buss.Out  = gold ^ invs;

    mux421_monitor #(.LATENCY(0), .CNT_W(16)) u0  (.Clock(clk), .nReset(rst_n), .bus(bus0.slave));
    mux421_monitor #(.LATENCY(2), .CNT_W(16)) u2  (.Clock(clk), .nReset(rst_n), .bus(bus2.slave));
    mux421_monitor #(.LATENCY(2), .CNT_W(16)) u2u (.Clock(clk), .nReset(rst_n), .bus(bus2u.slave));
    mux421_monitor #(.LATENCY(3), .CNT_W(16)) u3  (.Clock(clk), .nReset(rst_n), .bus(bus3.slave));
    mux421_monitor #(.LATENCY(0), .CNT_W(4))  us  (.Clock(clk), .nReset(rst_n), .bus(buss.slave));

    function automatic logic mm(input int d);
        case (d)
            0:       return bus0.Mismatch;
            1:       return bus2.Mismatch;
            2:       return bus2u.Mismatch;
            3:       return bus3.Mismatch;
            default: return buss.Mismatch;
        endcase
    endfunction

    // One clock; the oldest scoreboard entry is checked once its result is due
    task automatic step();
        logic e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() > sb_lat) begin
            e = sb_q.pop_front();
            checks++;
            if (mm(sb_dut) !== e) begin
                errors++;
                $display("FAIL sb_mismatch dut%0d cyc%0d: got %b expected %b", sb_dut, cyc, mm(sb_dut), e);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] idx, input logic exp_mm);
        valid = v;
        {sel, din} = idx;
        sb_q.push_back(v & exp_mm);
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        clear = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid = 1'($urandom);
            {sel, din} = 6'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({bus0.VectorCount, bus0.ErrorCount, bus0.Mismatch, bus0.Status, bus0.Pass} !== 36'd0) begin
                errors++;
                $display("FAIL reset_hold_u0: got vc=%0d ec=%0d mm=%b st=%b", bus0.VectorCount, bus0.ErrorCount, bus0.Mismatch, bus0.Status);
            end
            checks++;
            if (bus0.Coverage !== 64'd0 || bus3.Coverage !== 64'd0) begin
                errors++;
                $display("FAIL reset_hold_cov: got %h / %h expected 0", bus0.Coverage, bus3.Coverage);
            end
        end
        valid = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus3.VectorCount, bus3.Status, bus0.VectorCount, bus0.Status} !== 36'd0) begin
                errors++;
                $display("FAIL reset_release: got vc0=%0d st0=%b vc3=%0d st3=%b expected 0", bus0.VectorCount, bus0.Status, bus3.VectorCount, bus3.Status);
            end
        end
    endtask

    task automatic test_all64();
        int p0 = -1, p2 = -1, last = 0;
        do_clear();
        sb_dut = 0; sb_lat = 0;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 6'(i), 1'b0);
            if (p0 < 0 && bus0.Status == 2'b10) p0 = cyc;
            if (p2 < 0 && bus2.Status == 2'b10) p2 = cyc;
        end
        last = cyc;
        checks++;
        if (bus0.VectorCount !== 16'd64 || bus0.ErrorCount !== 16'd0) begin
            errors++;
            $display("FAIL all64_counts: got vc=%0d ec=%0d expected 64/0", bus0.VectorCount, bus0.ErrorCount);
        end
        checks++;
        if (bus0.Coverage !== {64{1'b1}} || bus0.CoverageFull !== 1'b1) begin
            errors++;
            $display("FAIL all64_cov: got %h full=%b expected all ones", bus0.Coverage, bus0.CoverageFull);
        end
        checks++;
        if (bus0.Status !== 2'b10 || bus0.Pass !== 1'b1) begin
            errors++;
            $display("FAIL all64_pass: got st=%b pass=%b expected 10/1", bus0.Status, bus0.Pass);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 6'd0, 1'b0);
            if (p2 < 0 && bus2.Status == 2'b10) p2 = cyc;
        end
        checks++;
        if (p0 != last) begin
            errors++;
            $display("FAIL lat0_pass_cycle: got %0d expected %0d", p0, last);
        end
        checks++;
        if (p2 != last + 2) begin
            errors++;
            $display("FAIL lat2_pass_cycle: got %0d expected %0d", p2, last + 2);
        end
        checks++;
        if (bus2.ErrorCount !== 16'd0 || bus2.VectorCount !== 16'd64) begin
            errors++;
            $display("FAIL lat2_counts: got vc=%0d ec=%0d expected 64/0", bus2.VectorCount, bus2.ErrorCount);
        end
        checks++;
        if (bus2u.ErrorCount === 16'd0 || bus2u.Status !== 2'b11) begin
            errors++;
            $display("FAIL lat2_undelayed: got ec=%0d st=%b expected ec>0 st=11", bus2u.ErrorCount, bus2u.Status);
        end
    endtask

    task automatic test_fault();
        do_clear();
        sb_dut = 0; sb_lat = 0;
        inj0 = 1'b1;
        drive(1'b1, 6'b10_0100, 1'b1);
        inj0 = 1'b0;
        checks++;
        if (bus0.ErrorCount !== 16'd1 || bus0.Status !== 2'b11) begin
            errors++;
            $display("FAIL fault_first: got ec=%0d st=%b expected 1/11", bus0.ErrorCount, bus0.Status);
        end
        drive(1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 64; i++) drive(1'b1, 6'(63 - i), 1'b0);
        checks++;
        if (bus0.Status !== 2'b11 || bus0.ErrorCount !== 16'd1 || bus0.VectorCount !== 16'd65) begin
            errors++;
            $display("FAIL fault_sticky: got st=%b ec=%0d vc=%0d expected 11/1/65", bus0.Status, bus0.ErrorCount, bus0.VectorCount);
        end
        xmode0 = 1'b1;
        drive(1'b1, 6'b01_0010, 1'b1);
        xmode0 = 1'b0;
        checks++;
        if (bus0.ErrorCount !== 16'd2) begin
            errors++;
            $display("FAIL fault_xout: got ec=%0d expected 2", bus0.ErrorCount);
        end
        drive(1'b0, 6'd0, 1'b0);
    endtask

    task automatic test_saturate();
        int pulses = 0;
        do_clear();
        sb_dut = 4; sb_lat = 0;
        invs = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 6'(i * 3), 1'b1);
            if (buss.Mismatch === 1'b1) pulses++;
        end
        invs = 1'b0;
        drive(1'b0, 6'd0, 1'b0);
        if (buss.Mismatch === 1'b1) pulses++;
        checks++;
        if (buss.VectorCount !== 4'd15 || buss.ErrorCount !== 4'd15) begin
            errors++;
            $display("FAIL sat_counts: got vc=%0d ec=%0d expected 15/15", buss.VectorCount, buss.ErrorCount);
        end
        checks++;
        if (pulses != 20 || buss.Status !== 2'b11) begin
            errors++;
            $display("FAIL sat_pulses: got %0d st=%b expected 20/11", pulses, buss.Status);
        end
    endtask

    task automatic load_lat3();
        sb_q.delete();
        sb_dut = 3; sb_lat = 100;
        inv3 = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 6'(i + 40), 1'b1);
        checks++;
        if (bus3.VectorCount !== 16'd2 || bus3.ErrorCount !== 16'd2) begin
            errors++;
            $display("FAIL clr_preload: got vc=%0d ec=%0d expected 2/2", bus3.VectorCount, bus3.ErrorCount);
        end
    endtask

    task automatic check_flushed(input string tag);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus3.VectorCount, bus3.ErrorCount, bus3.Mismatch, bus3.Status} !== 35'd0 || bus3.Coverage !== 64'd0) begin
                errors++;
                $display("FAIL %s_flush%0d: got vc=%0d ec=%0d mm=%b st=%b cov=%h expected all 0", tag, i,
                         bus3.VectorCount, bus3.ErrorCount, bus3.Mismatch, bus3.Status, bus3.Coverage);
            end
            drive(1'b0, 6'd0, 1'b0);
        end
    endtask

    task automatic test_clear();
        do_clear();
        load_lat3();
        clear = 1'b1;
        drive(1'b1, 6'd63, 1'b0);
        clear = 1'b0;
        check_flushed("clr");
        load_lat3();
        rst_n = 1'b0;
        valid = 1'b1;
        #1;
        checks++;
        if ({bus3.VectorCount, bus3.ErrorCount, bus3.Status} !== 34'd0) begin
            errors++;
            $display("FAIL rst_async: got vc=%0d ec=%0d st=%b expected 0", bus3.VectorCount, bus3.ErrorCount, bus3.Status);
        end
        #2;
        valid = 1'b0;
        rst_n = 1'b1;
        check_flushed("rst");
        inv3 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; valid = 1'b0; din = '0; sel = '0;
        inj0 = 1'b0; xmode0 = 1'b0; inv3 = 1'b0; invs = 1'b0;
        test_reset();
        test_all64();
        test_fault();
        test_saturate();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux421_monitor.md
Name: mux421_monitor

Overview:
- Clocked, self-checking monitor that sits directly downstream of the 4-to-1 mux DUV.
- Consumes the same stimulus the DUV sees plus the DUV's Out, and predicts the expected output.
- Compares after a configurable DUV latency, and accumulates vector, error and input-coverage statistics into a sticky pass/fail verdict.
- Replaces the combinational checker when the DUV or generator is clocked.

Parameters:
- LATENCY, 0, DUV latency in clock cycles between Valid-sampled inputs and the Out to compare. Legal range 0..8.
- CNT_W, 16, width of VectorCount and ErrorCount.

Ports:
- Clock  input  1  rising-edge clock.
- nReset  input  1  asynchronous active-low reset.
- Clear  input  1  synchronous clear of counters, coverage, pipeline and state.
- Valid  input  1  stimulus on In0..In3/Sel0/Sel1 is valid this cycle.
- In0, In1, In2, In3  input  1 each  mux data inputs as driven to the DUV.
- Sel0, Sel1  input  1 each  mux select; Sel1 is the MSB.
- Out  input  1  DUV output.
- Mismatch  output  1  one-cycle pulse per failed comparison.
- VectorCount  output  CNT_W  number of comparisons performed; saturating.
- ErrorCount  output  CNT_W  number of failed comparisons; saturating.
- Coverage  output  64  bit i set once input combination i has been compared.
- CoverageFull  output  1  all 64 Coverage bits set.
- Status  output  2  00 IDLE, 01 RUN, 10 PASS, 11 FAIL.
- Pass  output  1  Status==PASS.

Behaviour:
- Reset: nReset low asynchronously zeroes all outputs and flushes the compare pipeline; Status=IDLE.
- Prediction: expected = In[{Sel1,Sel0}], computed from inputs sampled in the Valid cycle.
- Coverage index = {Sel1,Sel0,In3,In2,In1,In0}.
- Compare pipeline:
  - A LATENCY-deep shift line carries {valid, expected, index}.
  - A comparison occurs in the cycle where the entry emerges: LATENCY cycles after the Valid cycle. LATENCY=0 means the Valid cycle itself.
  - Out is compared with case-inequality, so X or Z on Out counts as a mismatch.
- Results of a comparison at edge N are registered at edge N+1:
  - VectorCount increments.
  - Coverage[index] is set.
  - On failure, ErrorCount increments and Mismatch is high for exactly that one cycle.
- Counters saturate at all-ones and never wrap.
- Back-to-back Valid on every cycle is supported with no bubbles; throughput is 1 compare per cycle.
- FSM:
  - IDLE -> RUN on the first completed comparison. If that comparison fails, go directly to FAIL.
  - RUN -> FAIL on any mismatch.
  - RUN -> PASS when CoverageFull=1, ErrorCount=0 and no valid entry remains in the pipeline.
  - PASS -> FAIL on any later mismatch. PASS otherwise holds while further vectors are checked.
  - FAIL is sticky until Clear or nReset.
- Clear:
  - Zeroes counters, Coverage and pipeline; Status=IDLE.
  - Clear wins over a simultaneous Valid or completing comparison; that vector is neither counted nor covered.
  - In-flight entries are dropped.
- Reset mid-operation: same as Clear, but asynchronous.
- CoverageFull and Pass are combinational from registered state.

Optional Feature:
- MUX421_MONITOR_LOG_EN defined:
  - On every mismatch, $display the simulation time, Sel1, Sel0, In3..In0, expected and Out.
  - When Status first enters PASS or FAIL, $display a one-line summary with VectorCount and ErrorCount.
- Undefined: the monitor is silent, and port behaviour is identical.

Test Plan:
- Reset: hold nReset low with random inputs toggling -> all counters 0, Coverage 0, Mismatch 0, Status=00. Release -> values unchanged until the first Valid.
- LATENCY=0, correct DUV, all 64 combinations with Valid each cycle:
  - VectorCount=64, ErrorCount=0, Coverage all ones.
  - Status=10 and Pass=1 from the cycle after the last comparison.
- Fault injection, LATENCY=0: Sel1=1, Sel0=0, In2=1, others 0, Out=0 -> Mismatch high exactly one cycle, ErrorCount=1, Status=11. A further 64 correct vectors keep Status=11.
- LATENCY=2, DUV Out delayed by two registers, 64 vectors:
  - ErrorCount=0, PASS is reached 2 cycles later than in the LATENCY=0 run.
  - Same run with Out undelayed -> ErrorCount>0, Status=11.
- Saturation, CNT_W=4: 20 vectors with Out forced inverted -> VectorCount=15, ErrorCount=15, no wrap, Mismatch pulses 20 times.
- Clear, LATENCY=3: assert Clear together with Valid while 3 entries are in flight -> next cycle all counters and Coverage 0, Status=00, no Mismatch from the dropped entries. Repeat with nReset pulsed low mid-pipeline -> same result.
